// File: rtl/jk_arb_pkg.sv
// jk_arb_pkg: shared JK op codes and arbiter FSM state encodings
package jk_arb_pkg;
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;
  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_ACK} state_t;
endpackage

// File: rtl/jk_bit_cell.sv
// jk_bit_cell: one JK flip-flop of the shared bank, updated only when en=1
// ports: clk, reset (async, active-high), en (apply op), j/k (op bits), q (state)
module jk_bit_cell
  import jk_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic j,
  input  logic k,
  output logic q
);
  logic q_d, q_q;
  always_comb
    q_d = !en                ? q_q   :
          {j, k} == JK_SET   ? 1'b1  :
          {j, k} == JK_CLR   ? 1'b0  :
          {j, k} == JK_TGL   ? ~q_q  : q_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) q_q <= 1'b0;
    else       q_q <= q_d;
  assign q = q_q;
endmodule

// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: round-robin arbiter sharing one JK flip-flop bank among NREQ requesters
// ports: clk, reset (async, active-high), req/op/mask per requester in,
//        gnt (one-hot grant), ack (one-cycle done pulse), q (bank state), busy (not idle)
// JK_BANK_OPCNT_EN adds op_cnt, a 16-bit wrapping count of completed ops
module jk_bank_arbiter
  import jk_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [2*NREQ-1:0]     op,
  input  logic [WIDTH*NREQ-1:0] mask,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      q,
  output logic                  busy
`ifdef JK_BANK_OPCNT_EN
  ,
  output logic [15:0]           op_cnt
`endif
);
  localparam int IW = $clog2(NREQ);
  state_t            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d, win_q, win_d, sel;
  logic [NREQ-1:0]   gnt_q, gnt_d, ack_q, ack_d;
  logic              upd;
  logic [1:0]        op_w;
  logic [WIDTH-1:0]  mask_w;
  assign op_w   = op[2*win_q +: 2];
  assign mask_w = mask[WIDTH*win_q +: WIDTH];
  // scan from the highest offset down so the lowest offset from ptr wins
  always_comb begin
    sel = ptr_q;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req[(int'(ptr_q) + k) % NREQ]) sel = IW'((int'(ptr_q) + k) % NREQ);
  end
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    upd     = 1'b0;
    case (state_q)
      ST_IDLE:
        if (|req) begin
          win_d   = sel;
          gnt_d   = NREQ'(1) << sel;
          state_d = ST_GRANT;
        end
      ST_GRANT: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
        // a withdrawn request aborts: no update, no ack, pointer kept
        if (req[win_q]) begin
          upd        = 1'b1;
          ack_d      = NREQ'(1) << win_q;
          ptr_d      = win_q == IW'(NREQ - 1) ? '0 : win_q + 1'b1;
          state_d    = ST_ACK;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
    end
  for (genvar b = 0; b < WIDTH; b++) begin : g_bank
    jk_bit_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .en    (upd & mask_w[b]),
      .j     (op_w[1]),
      .k     (op_w[0]),
      .q     (q[b])
    );
  end
  assign gnt  = gnt_q;
  assign ack  = ack_q;
  assign busy = state_q != ST_IDLE;
`ifdef JK_BANK_OPCNT_EN
  logic [15:0] cnt_q, cnt_d;
  always_comb cnt_d = upd ? cnt_q + 16'd1 : cnt_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  assign op_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_jk_bank_arbiter.sv
// tb_jk_bank_arbiter: scoreboard bench for the round-robin JK bank arbiter
module tb_jk_bank_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [2*N-1:0] op = '0;
  logic [W*N-1:0] mask = '0;
  logic [N-1:0]   gnt, ack;
  logic [W-1:0]   q;
  logic           busy;
`ifdef JK_BANK_OPCNT_EN
  logic [15:0]    op_cnt;
  int             exp_cnt = 0;
`endif
  int errors = 0;
  int checks = 0;
  logic [N-1:0]   gq[$];
  logic [N+W-1:0] aq[$];

  jk_bank_arbiter #(.NREQ(N), .WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .op     (op),
    .mask   (mask),
    .gnt    (gnt),
    .ack    (ack),
    .q      (q),
    .busy   (busy)
`ifdef JK_BANK_OPCNT_EN
    ,
    .op_cnt (op_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [1:0] o, input logic [W-1:0] m);
    op[2*i +: 2]   = o;
    mask[W*i +: W] = m;
  endtask

  // one full op: called #1 after an edge with the FSM idle
  task automatic run(input logic [N-1:0] r, input int w, input logic [W-1:0] eq);
    logic [N-1:0] oh;
    oh = N'(1) << w;
    gq.push_back(oh);
    aq.push_back({oh, eq});
    req = r;
    @(posedge clk);
    @(posedge clk);
    #1 req = '0;
    @(posedge clk);
    #1;
`ifdef JK_BANK_OPCNT_EN
    exp_cnt++;
`endif
  endtask

  // monitor: pops the scoreboard whenever the DUT shows a grant or an ack
  always @(negedge clk) begin
    if (!reset && (gnt != '0 || ack != '0)) begin
      check("gnt_ack_exclusive", {31'b0, gnt != '0 && ack != '0}, 32'd0);
      check("busy_active", {31'b0, busy}, 32'd1);
      if (gnt != '0) begin
        if (gq.size() == 0) check("gnt_unexpected", {28'b0, gnt}, 32'd0);
        else check("gnt", {28'b0, gnt}, {28'b0, gq.pop_front()});
      end
      if (ack != '0) begin
        if (aq.size() == 0) check("ack_unexpected", {20'b0, ack, q}, 32'd0);
        else check("ack_q", {20'b0, ack, q}, {20'b0, aq.pop_front()});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] rr_q[5];
    rr_q = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h0E};
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", {28'b0, gnt}, 32'd0);
    check("rst_ack", {28'b0, ack}, 32'd0);
    check("rst_q", {24'b0, q}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
`ifdef JK_BANK_OPCNT_EN
    check("rst_op_cnt", {16'b0, op_cnt}, 32'd0);
`endif
    reset = 1'b0;
    @(posedge clk);
    #1;
    set_op(0, 2'b10, 8'h0F);
    run(4'b0001, 0, 8'h0F);
    check("busy_idle", {31'b0, busy}, 32'd0);
    set_op(1, 2'b11, 8'hFF);
    run(4'b0010, 1, 8'hF0);
    set_op(1, 2'b01, 8'hF0);
    run(4'b0010, 1, 8'h00);
    set_op(3, 2'b11, 8'h00);
    run(4'b1000, 3, 8'h00);
    for (int i = 0; i < N; i++) set_op(i, 2'b11, W'(1) << i);
    for (int k = 0; k < 5; k++) begin
      gq.push_back(N'(1) << (k % N));
      aq.push_back({N'(1) << (k % N), rr_q[k]});
    end
    req = 4'b1111;
    repeat (14) @(posedge clk);
    #1 req = '0;
    @(posedge clk);
    #1;
`ifdef JK_BANK_OPCNT_EN
    exp_cnt += 5;
`endif
    set_op(1, 2'b00, 8'hFF);
    run(4'b0010, 1, 8'h0E);
    set_op(2, 2'b10, 8'hFF);
    gq.push_back(4'b0100);
    req = 4'b0100;
    @(posedge clk);
    #1 req = '0;
    @(posedge clk);
    #1;
    check("abort_q", {24'b0, q}, 32'h0E);
    check("abort_busy", {31'b0, busy}, 32'd0);
    run(4'b1111, 2, 8'hFF);
    set_op(0, 2'b01, 8'h55);
    run(4'b0001, 0, 8'hAA);
`ifdef JK_BANK_OPCNT_EN
    check("op_cnt", {16'b0, op_cnt}, exp_cnt);
`endif
    req = 4'b0010;
    @(posedge clk);
    #1;
    check("gnt_before_reset", {28'b0, gnt}, 32'h2);
    reset = 1'b1;
    #1;
    check("midop_gnt", {28'b0, gnt}, 32'd0);
    check("midop_ack", {28'b0, ack}, 32'd0);
    check("midop_q", {24'b0, q}, 32'd0);
    check("midop_busy", {31'b0, busy}, 32'd0);
`ifdef JK_BANK_OPCNT_EN
    check("midop_op_cnt", {16'b0, op_cnt}, 32'd0);
    exp_cnt = 0;
`endif
    req = '0;
    @(posedge clk);
    #1 reset = 1'b0;
    set_op(0, 2'b10, 8'h01);
    run(4'b1111, 0, 8'h01);
`ifdef JK_BANK_OPCNT_EN
    check("op_cnt_after_reset", {16'b0, op_cnt}, exp_cnt);
`endif
    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_drained", gq.size() + aq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
